// File: rtl/switch_pkg.sv
// Shared switch definitions: default widths, arbiter states and the
// source-port field that the input arbiter stamps into tuser.
package switch_pkg;

  localparam int DATA_WIDTH_DEF  = 64;
  localparam int TUSER_WIDTH_DEF = 128;
  localparam int SRC_PORT_OFS    = 16;
  localparam int SRC_PORT_W      = 8;
  localparam int PKT_CNT_W       = 32;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } arb_state_e;

  // One-hot source code 1<<(2*port), truncated to the 8-bit field.
  function automatic logic [SRC_PORT_W-1:0] src_code(input int unsigned port);
    logic [15:0] t;
    t = 16'd1 << (2 * port);
    return t[SRC_PORT_W-1:0];
  endfunction

endpackage

// File: rtl/input_arbiter_rr_picker.sv
// Rotating first-valid search: returns the first set request at or after
// i_ptr, wrapping modulo N.
module rr_picker #(
  parameter  int N  = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [PW-1:0] o_idx,
  output logic          o_found
);

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    int j;
    j       = 0;
    o_idx   = '0;
    o_found = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(i_ptr) + k) % N;
      if (i_req[j]) begin
        o_idx   = PW'(j);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/input_arbiter.sv
// Packet-level round-robin merge of NUM_PORTS AXI-Stream inputs onto one
// output. One IDLE bubble precedes every packet; the grant is held until the
// tlast beat is accepted. tuser[23:16] is replaced with the source code.
// Optional: define INPUT_ARBITER_PKT_CNT_EN to add per-port packet counters.
module input_arbiter
  import switch_pkg::*;
#(
  parameter int NUM_PORTS   = 4,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int TUSER_WIDTH = TUSER_WIDTH_DEF
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [NUM_PORTS*TUSER_WIDTH-1:0] s_axis_tuser,
  input  logic [NUM_PORTS-1:0]             s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]             s_axis_tlast,
  output logic [NUM_PORTS-1:0]             s_axis_tready,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]          m_axis_tkeep,
  output logic [TUSER_WIDTH-1:0]           m_axis_tuser,
  output logic                             m_axis_tlast,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready
`ifdef INPUT_ARBITER_PKT_CNT_EN
  ,
  output logic [NUM_PORTS*PKT_CNT_W-1:0]   pkt_cnt
`endif
);

  localparam int KW = DATA_WIDTH / 8;
  localparam int PW = $clog2(NUM_PORTS);

  // Per-port views of the flat input buses.
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  w_data;
  logic [NUM_PORTS-1:0][KW-1:0]          w_keep;
  logic [NUM_PORTS-1:0][TUSER_WIDTH-1:0] w_user;

  assign w_data = s_axis_tdata;
  assign w_keep = s_axis_tkeep;
  assign w_user = s_axis_tuser;

  arb_state_e    r_state, w_state_nxt;
  logic [PW-1:0] r_sel, r_rr_ptr;
  logic [PW-1:0] w_pick_idx;
  logic          w_pick_found;
  logic          w_acc, w_last_acc;

  rr_picker #(.N(NUM_PORTS)) u_pick (
    .i_req   (s_axis_tvalid),
    .i_ptr   (r_rr_ptr),
    .o_idx   (w_pick_idx),
    .o_found (w_pick_found)
  );

  // Beat accepted on the granted port, and whether it closes the packet.
  assign w_acc      = (r_state == PKT) && s_axis_tvalid[r_sel] && m_axis_tready;
  assign w_last_acc = w_acc && s_axis_tlast[r_sel];

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and handshake outputs; IDLE keeps both sides closed.
  always_comb begin
    w_state_nxt   = r_state;
    m_axis_tvalid = 1'b0;
    s_axis_tready = '0;
    case (r_state)
      IDLE: if (w_pick_found) w_state_nxt = PKT;
      PKT: begin
        m_axis_tvalid        = s_axis_tvalid[r_sel];
        s_axis_tready[r_sel] = m_axis_tready;
        if (w_last_acc) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Grant capture in IDLE; pointer advances past the winner on tlast.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sel    <= '0;
      r_rr_ptr <= '0;
    end else begin
      if (r_state == IDLE && w_pick_found) r_sel <= w_pick_idx;
      if (w_last_acc)
        r_rr_ptr <= (r_sel == PW'(NUM_PORTS - 1)) ? '0 : r_sel + 1'b1;
    end
  end

  // Payload mux from the granted port with the source field stamped in.
  always_comb begin
    m_axis_tdata = w_data[r_sel];
    m_axis_tkeep = w_keep[r_sel];
    m_axis_tlast = s_axis_tlast[r_sel];
    m_axis_tuser = w_user[r_sel];
    m_axis_tuser[SRC_PORT_OFS +: SRC_PORT_W] = src_code(32'(r_sel));
  end

`ifdef INPUT_ARBITER_PKT_CNT_EN
  logic [NUM_PORTS-1:0][PKT_CNT_W-1:0] r_pkt_cnt;

  // Count completed packets per source port; wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (!reset)          r_pkt_cnt        <= '0;
    else if (w_last_acc) r_pkt_cnt[r_sel] <= r_pkt_cnt[r_sel] + 1'b1;
  end

  assign pkt_cnt = r_pkt_cnt;
`endif

endmodule

// File: tb/tb_input_arbiter.sv
// Scoreboard bench for input_arbiter: stimulus pushes per-port beats and the
// expected output beats; a negedge monitor pops and compares.
module tb_input_arbiter;

  localparam int NP = 4;
  localparam int DW = 64;
  localparam int KW = DW / 8;
  localparam int UW = 128;

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    logic          l;
  } beat_t;

  typedef struct {
    beat_t b;
    int    gap;   // expected cycles since previous output beat, -1 = any
    int    abs;   // expected absolute monitor cycle, -1 = any
  } exp_t;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NP*DW-1:0]    s_tdata;
  logic [NP*KW-1:0]    s_tkeep;
  logic [NP*UW-1:0]    s_tuser;
  logic [NP-1:0]       s_tvalid, s_tlast, s_tready;
  logic [DW-1:0]       m_tdata;
  logic [KW-1:0]       m_tkeep;
  logic [UW-1:0]       m_tuser;
  logic                m_tlast, m_tvalid, m_tready;
`ifdef INPUT_ARBITER_PKT_CNT_EN
  logic [NP*32-1:0]    pkt_cnt;
`endif

  input_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .TUSER_WIDTH(UW)) dut (
    .clk           (clk),
    .reset         (rst_n),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tuser  (s_tuser),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tuser  (m_tuser),
    .m_axis_tlast  (m_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready)
`ifdef INPUT_ARBITER_PKT_CNT_EN
    ,
    .pkt_cnt       (pkt_cnt)
`endif
  );

  always #5 clk = ~clk;

  beat_t pq[NP][$];
  exp_t  sb[$];
  int    checks = 0, errors = 0;
  int    cyc = 0, n_acc = 0, last_cyc = 0, pkt_id = 0;
  logic  tog_en = 1'b0;
  logic [NP-1:0] drv_hs;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] src_exp(input int p);
    case (p)
      0: return 8'h01;
      1: return 8'h04;
      2: return 8'h10;
      default: return 8'h40;
    endcase
  endfunction

  // Queue a packet on port p; only the first nexp beats are expected out.
  task automatic send_pkt(input int p, input int n, input int nexp,
                          input int gfirst, input int abs_first, input bit gchk);
    beat_t b;
    exp_t  e;
    for (int i = 0; i < n; i++) begin
      b.d = {8'(p), 8'(pkt_id), 16'(i), $urandom};
      b.k = 8'($urandom);
      b.u = {$urandom, $urandom, $urandom, $urandom};
      b.l = (i == n - 1);
      pq[p].push_back(b);
      if (i < nexp) begin
        e.b          = b;
        e.b.u[23:16] = src_exp(p);
        e.gap        = !gchk ? -1 : (i == 0) ? gfirst : 1;
        e.abs        = (i == 0) ? abs_first : (abs_first < 0 ? -1 : abs_first + i);
        sb.push_back(e);
      end
    end
    pkt_id++;
  endtask

  function automatic bit pending();
    for (int p = 0; p < NP; p++) if (pq[p].size() != 0) return 1'b1;
    return sb.size() != 0;
  endfunction

  task automatic drain();
    int t = 0;
    while (pending() && t < 300) begin @(posedge clk); t++; end
    if (t >= 300) begin
      checks++; errors++;
      $display("FAIL drain_timeout sb=%0d want 0", sb.size());
      for (int p = 0; p < NP; p++) pq[p].delete();
      sb.delete();
    end
    repeat (2) @(posedge clk);
    #2;
  endtask

  // Source driver: retire handshaken beats, then present each queue head.
  always begin
    @(posedge clk);
    drv_hs = s_tvalid & s_tready;
    #1;
    for (int p = 0; p < NP; p++) begin
      if (!rst_n) pq[p].delete();
      else if (drv_hs[p] && pq[p].size() != 0) void'(pq[p].pop_front());
      if (pq[p].size() != 0) begin
        s_tvalid[p]           = 1'b1;
        s_tdata[p*DW +: DW]   = pq[p][0].d;
        s_tkeep[p*KW +: KW]   = pq[p][0].k;
        s_tuser[p*UW +: UW]   = pq[p][0].u;
        s_tlast[p]            = pq[p][0].l;
      end else begin
        s_tvalid[p] = 1'b0;
        s_tlast[p]  = 1'b0;
      end
    end
  end

  // Backpressure pattern: flip output ready every cycle while enabled.
  always begin
    @(posedge clk);
    #1;
    if (tog_en) m_tready = ~m_tready;
  end

  // Monitor: compare every accepted output beat against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst_n && m_tvalid && m_tready) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_beat got data %h want none", m_tdata);
      end else begin
        e = sb.pop_front();
        chk("data", 128'(m_tdata), 128'(e.b.d));
        chk("keep", 128'(m_tkeep), 128'(e.b.k));
        chk("user", m_tuser, e.b.u);
        chk("last", 128'(m_tlast), 128'(e.b.l));
        if (e.gap >= 0) chk("gap", 128'(cyc - last_cyc), 128'(e.gap));
        if (e.abs >= 0) chk("first_beat_cyc", 128'(cyc), 128'(e.abs));
      end
      n_acc++;
      last_cyc = cyc;
    end
    if (rst_n) chk("sready_onehot0", 128'($onehot0(s_tready)), 128'(1));
  end

  initial begin
    int t0, base, tmo;
    #1000000;
    $display("FAIL watchdog expired got running want finished");
    $fatal(1);
  end

  initial begin
    int t0, base, tmo;
    rst_n = 1'b0; m_tready = 1'b1;
    s_tvalid = '0; s_tlast = '0; s_tdata = '0; s_tkeep = '0; s_tuser = '0;

    // Reset values, then idle with no requests.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mvalid", 128'(m_tvalid), 128'(0));
    chk("rst_sready", 128'(s_tready), 128'(0));
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("idle_mvalid", 128'(m_tvalid), 128'(0));
      chk("idle_sready", 128'(s_tready), 128'(0));
    end

    // Single 3-beat packet from port 2; first beat three monitor cycles on.
    @(posedge clk); #2;
    t0 = cyc;
    send_pkt(2, 3, 3, -1, t0 + 3, 1);
    drain();

    // rr_ptr=3: ports 3 and 0 single-beat -> 3 then 0; then 1 before 0.
    send_pkt(3, 1, 1, -1, -1, 1);
    send_pkt(0, 1, 1, 2, -1, 1);
    drain();
    send_pkt(1, 1, 1, -1, -1, 1);
    send_pkt(0, 1, 1, 2, -1, 1);
    drain();

    // Fairness from reset: all ports busy with 2-beat packets.
    rst_n = 1'b0; repeat (2) @(posedge clk); #2 rst_n = 1'b1;
    for (int k = 0; k < 8; k++) send_pkt(k % NP, 2, 2, (k == 0) ? -1 : 2, -1, 1);
    drain();

    // Backpressure on a 4-beat port1 packet; late requests wait their turn.
    send_pkt(1, 4, 4, -1, -1, 0);
    tog_en = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    send_pkt(2, 1, 1, -1, -1, 0);
    send_pkt(0, 1, 1, -1, -1, 0);
    drain();
    tog_en = 1'b0;
    @(posedge clk); #2 m_tready = 1'b1;

    // Reset after beat 2 of a 5-beat port3 packet.
    base = n_acc;
    send_pkt(3, 5, 2, -1, -1, 1);
    tmo = 0;
    while (n_acc < base + 2 && tmo < 100) begin @(posedge clk); tmo++; end
    if (tmo >= 100) begin
      checks++; errors++;
      $display("FAIL midpkt_wait got %0d beats want 2", n_acc - base);
    end
    #2 m_tready = 1'b0; rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_mvalid", 128'(m_tvalid), 128'(0));
    chk("midrst_sready", 128'(s_tready), 128'(0));
    @(posedge clk); #2 rst_n = 1'b1; m_tready = 1'b1;
    chk("midrst_sb_empty", 128'(sb.size()), 128'(0));
    send_pkt(0, 2, 2, -1, -1, 1);
    send_pkt(2, 2, 2, 2, -1, 1);
    drain();
    send_pkt(1, 3, 3, -1, -1, 1);
    drain();
`ifdef INPUT_ARBITER_PKT_CNT_EN
    chk("pkt_cnt0", 128'(pkt_cnt[0*32 +: 32]), 128'(1));
    chk("pkt_cnt1", 128'(pkt_cnt[1*32 +: 32]), 128'(1));
    chk("pkt_cnt2", 128'(pkt_cnt[2*32 +: 32]), 128'(1));
    chk("pkt_cnt3", 128'(pkt_cnt[3*32 +: 32]), 128'(0));
`endif
    chk("sb_final_empty", 128'(sb.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/input_arbiter.md
INPUT_ARBITER -- requirements
Module: input_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4: number of AXI-Stream input ports, range 2..8.
REQ-002 SHALL have parameter DATA_WIDTH, default 64: tdata width in bits; tkeep width is DATA_WIDTH/8.
REQ-003 SHALL have parameter TUSER_WIDTH, default 128: tuser width in bits; bits [23:16] are the source-port field.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port s_axis_tdata, input, NUM_PORTS*DATA_WIDTH bits: input data, with port i in slice i.
REQ-007 SHALL have port s_axis_tkeep, input, NUM_PORTS*DATA_WIDTH/8 bits: input byte enables, with port i in slice i.
REQ-008 SHALL have port s_axis_tuser, input, NUM_PORTS*TUSER_WIDTH bits: input sideband, with port i in slice i.
REQ-009 SHALL have ports s_axis_tvalid and s_axis_tlast, input, NUM_PORTS bits each: per-port valid and end-of-packet.
REQ-010 SHALL have port s_axis_tready, output, NUM_PORTS bits: per-port ready.
REQ-011 SHALL have ports m_axis_tdata, m_axis_tkeep, m_axis_tuser and m_axis_tlast, outputs, with the per-port widths above: merged output stream.
REQ-012 SHALL have ports m_axis_tvalid (output, 1 bit) and m_axis_tready (input, 1 bit): output handshake.

Function
REQ-013 SHALL merge the NUM_PORTS input streams into one output stream, arbitrating per packet and never interleaving beats of different packets.
REQ-014 SHALL implement two states:
- IDLE: s_axis_tready = 0 and m_axis_tvalid = 0.
- PKT: the granted port sel is connected to the output.
REQ-015 In IDLE, when any s_axis_tvalid bit is 1, SHALL register sel as the first valid port found searching rr_ptr, rr_ptr+1, ... modulo NUM_PORTS, and enter PKT on the next cycle.
REQ-016 In PKT, SHALL drive m_axis_* combinationally from port sel.
REQ-017 In PKT, SHALL drive s_axis_tready[sel] = m_axis_tready and all other s_axis_tready bits = 0.
REQ-018 On a PKT beat with tvalid & tready & tlast, SHALL return to IDLE and set rr_ptr = (sel+1) mod NUM_PORTS, wrapping from NUM_PORTS-1 to 0.
REQ-019 SHALL give each packet a latency of one bubble cycle (IDLE) before its first beat; within a packet, throughput is one beat per cycle while m_axis_tready = 1.
REQ-020 SHALL overwrite m_axis_tuser[23:16] with the one-hot source code 1<<(2*sel), so port0=0x01, port1=0x04, port2=0x10, port3=0x40; all other tuser bits pass through unchanged.
REQ-021 SHALL hold the grant across stalls (m_axis_tready = 0 or s_axis_tvalid[sel] = 0) until tlast is accepted.
REQ-022 SHALL not affect the grant in progress when other ports assert or deassert tvalid during PKT.
REQ-023 SHALL treat a single-beat packet (tlast on the first beat) as a complete packet and return to IDLE.

Reset
REQ-024 While reset = 0 at a clock edge, SHALL set state = IDLE, rr_ptr = 0, sel = 0, s_axis_tready = 0 and m_axis_tvalid = 0.
REQ-025 On reset mid-packet, SHALL abandon the packet in progress; arbitration restarts from port 0 after reset is released.

Configuration
REQ-026 With INPUT_ARBITER_PKT_CNT_EN defined, SHALL add output pkt_cnt, NUM_PORTS*32 bits, one counter per port.
REQ-027 Each pkt_cnt counter SHALL increment when that port's tlast beat is accepted, wrap at 2^32, and reset to 0.
REQ-028 Without INPUT_ARBITER_PKT_CNT_EN, the pkt_cnt port and counter logic SHALL be absent and all other behaviour identical.

Structure
REQ-029 SHALL take the following from shared package switch_pkg: the width constants, the arbiter state enum (IDLE, PKT) and the source-port field offset 16.
REQ-030 SHALL implement the rotating first-valid search in one sub-module, rr_picker (inputs: request vector and rr_ptr; outputs: index and found).

Verification
REQ-031 Idle: after reset with no tvalid -> m_axis_tvalid = 0 and s_axis_tready = 0 indefinitely.
REQ-032 Single port: port2 sends a 3-beat packet with m_axis_tready = 1 -> output beats appear on cycles 2..4 after tvalid, tuser[23:16] = 0x10, then rr_ptr = 3.
REQ-033 Fairness: all 4 ports continuously send 2-beat packets -> grant order is 0,1,2,3,0,... with one bubble cycle between packets.
REQ-034 Backpressure: m_axis_tready toggled 1,0,1,0 during a 4-beat packet from port1 -> no beat lost or duplicated, no other port granted until tlast is accepted.
REQ-035 Wrap and single-beat: rr_ptr = 3, ports 3 and 0 send 1-beat packets -> port3 first, then port0, rr_ptr ends at 1.
REQ-036 Reset mid-packet: reset = 0 after beat 2 of a 5-beat packet -> outputs go to reset values the next cycle; after release, a fresh packet on port1 is granted normally (pkt_cnt[1] = 1 when INPUT_ARBITER_PKT_CNT_EN is defined).
